// File: rtl/mic_level_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mic_level_reader_pkg
// Description : Shared FSM encoding and sample/magnitude width constants for
//               the microphone level reader.
// Revision    : 1.0 - initial release
// ============================================================================
package mic_level_reader_pkg;

  // Codec words are 32-bit; only the top half carries useful precision.
  localparam int SAMPLE_HI = 31;
  localparam int SAMPLE_LO = 16;

  // Width of a single-channel sample and of the averaged magnitude.
  localparam int MAG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAG  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mic_level_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : mic_level_reader_if
// Description : Audio_Controller input-stream handshake: sample-pair
//               availability, the two channel words and the pop strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface mic_level_reader_if;

  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;

  // Audio_Controller side: offers samples, receives the pop strobe.
  modport master (
    output audio_in_available,
    output left_channel_audio_in,
    output right_channel_audio_in,
    input  read_audio_in
  );

  // Reader side: consumes samples, issues the pop strobe.
  modport slave (
    input  audio_in_available,
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    output read_audio_in
  );

endinterface
`default_nettype wire

// File: rtl/mic_level_reader_audio_mag.sv
`default_nettype none
// ============================================================================
// Module      : mic_level_reader_audio_mag
// Description : Combinational stereo magnitude: saturated |L| and |R|,
//               summed on 17 bits and halved back to 16 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_level_reader_audio_mag
  import mic_level_reader_pkg::*;
(
  input  logic signed [MAG_W-1:0] l_i,
  input  logic signed [MAG_W-1:0] r_i,
  output logic        [MAG_W-1:0] mag_o
);

  // -32768 has no positive 16-bit counterpart, so it clamps to +32767.
  function automatic logic [MAG_W-1:0] sat_abs(input logic signed [MAG_W-1:0] x);
    logic [MAG_W-1:0] res;
    if (x == {1'b1, {(MAG_W-1){1'b0}}}) begin
      res = {1'b0, {(MAG_W-1){1'b1}}};
    end else if (x[MAG_W-1]) begin
      res = -x;
    end else begin
      res = x;
    end
    return res;
  endfunction

  logic [MAG_W:0] sum_w;

  // Average of the two channel magnitudes; the extra sum bit avoids overflow.
  always_comb begin
    sum_w = {1'b0, sat_abs(l_i)} + {1'b0, sat_abs(r_i)};
  end

  assign mag_o = sum_w[MAG_W:1];

endmodule
`default_nettype wire

// File: rtl/mic_level_reader.sv
`default_nettype none
// ============================================================================
// Module      : mic_level_reader
// Description : Pops microphone sample pairs, averages their magnitude over
//               2^WIN_LOG2 samples, reports window mean/peak and drives a
//               hysteresis blow detector.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_level_reader
  import mic_level_reader_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 enable,
  mic_level_reader_if.slave    audio,
  input  logic [MAG_W-1:0]     th_on,
  input  logic [MAG_W-1:0]     th_off,
  output logic [MAG_W-1:0]     level,
  output logic [MAG_W-1:0]     peak,
  output logic                 level_valid,
  output logic                 blow_active,
  output logic                 blow_pulse
);

  localparam int ACC_W = MAG_W + WIN_LOG2;

  state_e                   state_q, state_d;
  logic                     read_w;
  logic signed [MAG_W-1:0]  l_q, r_q;
  logic        [MAG_W-1:0]  mag_w, mag_q;
  logic        [ACC_W-1:0]  acc_q, acc_sum_w;
  logic     [WIN_LOG2-1:0]  cnt_q;
  logic        [MAG_W-1:0]  runpeak_q, peak_max_w;
  logic        [MAG_W-1:0]  level_q, peak_q;
  logic                     lv_q, blow_q, pulse_q;
  logic                     unused_lo_w;

  // Lower halves of the codec words carry no useful precision.
  assign unused_lo_w = ^{audio.left_channel_audio_in[SAMPLE_LO-1:0],
                         audio.right_channel_audio_in[SAMPLE_LO-1:0]};

  mic_level_reader_audio_mag u_audio_mag (
    .l_i   (l_q),
    .r_i   (r_q),
    .mag_o (mag_w)
  );

  assign acc_sum_w  = acc_q + {{WIN_LOG2{1'b0}}, mag_q};
  assign peak_max_w = (mag_q > runpeak_q) ? mag_q : runpeak_q;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one pop, one magnitude cycle, one accumulate cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (read_w) state_d = ST_MAG;
      ST_MAG:  state_d = ST_ACC;
      ST_ACC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pop strobe: only from IDLE, so it can never fire on back-to-back cycles;
  // gated by resetn so no strobe escapes while reset is held.
  always_comb begin
    read_w = resetn && (state_q == ST_IDLE) && enable && audio.audio_in_available;
  end

  assign audio.read_audio_in = read_w;

  // Sample capture, magnitude register, window accumulation and reporting.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      l_q       <= '0;
      r_q       <= '0;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      runpeak_q <= '0;
      level_q   <= '0;
      peak_q    <= '0;
      lv_q      <= 1'b0;
    end else begin
      lv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (read_w) begin
            l_q <= audio.left_channel_audio_in[SAMPLE_HI:SAMPLE_LO];
            r_q <= audio.right_channel_audio_in[SAMPLE_HI:SAMPLE_LO];
          end else if (!enable) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            runpeak_q <= '0;
          end
        end
        ST_MAG: begin
          mag_q <= mag_w;
        end
        ST_ACC: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            level_q   <= acc_sum_w[ACC_W-1:WIN_LOG2];
            peak_q    <= peak_max_w;
            lv_q      <= 1'b1;
            acc_q     <= '0;
            runpeak_q <= '0;
          end else begin
            acc_q     <= acc_sum_w;
            runpeak_q <= peak_max_w;
          end
        end
        default: ;
      endcase
    end
  end

  // Hysteresis detector, evaluated once per fresh level; set wins over clear.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      blow_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (lv_q) begin
        if (level_q >= th_on) begin
          blow_q  <= 1'b1;
          pulse_q <= !blow_q;
        end else if (level_q < th_off) begin
          blow_q <= 1'b0;
        end
      end
    end
  end

  assign level       = level_q;
  assign peak        = peak_q;
  assign level_valid = lv_q;
  assign blow_active = blow_q;
  assign blow_pulse  = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_mic_level_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic_level_reader
// Description : Self-checking bench for mic_level_reader with a window-level
//               behavioural model and directed sample sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_level_reader;

  localparam int W   = 2;
  localparam int WIN = 1 << W;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        enable   = 1'b0;
  logic [15:0] th_on    = 16'hFFFF;
  logic [15:0] th_off   = 16'h0000;
  logic [15:0] level, peak;
  logic        level_valid, blow_active, blow_pulse;

  mic_level_reader_if aif ();

  mic_level_reader #(.WIN_LOG2(W)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .enable      (enable),
    .audio       (aif),
    .th_on       (th_on),
    .th_off      (th_off),
    .level       (level),
    .peak        (peak),
    .level_valid (level_valid),
    .blow_active (blow_active),
    .blow_pulse  (blow_pulse)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; int lvl; int pk; } ev_t;

  int   win[$];
  ev_t  evq[$];
  int   m_level, m_peak, m_blow, m_lv, m_pulse;
  int   blow_next, blow_cyc, last_rd, cyc;
  bit   exp_rd;

  function automatic int chan_abs(input logic [31:0] s);
    logic [15:0] hi;
    int v;
    hi = s[31:16];
    v  = $signed(hi);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic void model_reset();
    win.delete();
    evq.delete();
    m_level = 0; m_peak = 0; m_blow = 0; m_lv = 0; m_pulse = 0;
    blow_next = 0; blow_cyc = -1; last_rd = -100;
  endfunction

  // Compare process: one check of every output per cycle, mid-cycle.
  initial begin : compare
    cyc = 0;
    model_reset();
    forever begin
      @(negedge CLOCK_50);
      if (!resetn) begin
        model_reset();
        check("rst_read",  aif.read_audio_in, 0);
        check("rst_level", level, 0);
        check("rst_peak",  peak, 0);
        check("rst_lv",    level_valid, 0);
        check("rst_blow",  blow_active, 0);
        check("rst_pulse", blow_pulse, 0);
      end else begin
        m_lv = 0;
        m_pulse = 0;
        if (blow_cyc == cyc) begin
          m_pulse = (blow_next != 0 && m_blow == 0) ? 1 : 0;
          m_blow  = blow_next;
        end
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          m_lv    = 1;
          m_level = evq[0].lvl;
          m_peak  = evq[0].pk;
          void'(evq.pop_front());
          if (m_level >= int'(th_on))       blow_next = 1;
          else if (m_level < int'(th_off))  blow_next = 0;
          else                              blow_next = m_blow;
          blow_cyc = cyc + 1;
        end
        // DUT is idle whenever no pop occurred in the previous two cycles.
        exp_rd = aif.audio_in_available && enable && (cyc - last_rd > 2);
        check("read",  aif.read_audio_in, {31'd0, exp_rd});
        check("level", level, m_level);
        check("peak",  peak, m_peak);
        check("lv",    level_valid, m_lv);
        check("blow",  blow_active, m_blow);
        check("pulse", blow_pulse, m_pulse);
        if (exp_rd) begin
          win.push_back((chan_abs(aif.left_channel_audio_in) +
                         chan_abs(aif.right_channel_audio_in)) / 2);
          last_rd = cyc;
          if (win.size() == WIN) begin
            int s, mx;
            s = 0; mx = 0;
            foreach (win[k]) begin
              s += win[k];
              if (win[k] > mx) mx = win[k];
            end
            evq.push_back('{cyc + 3, s / WIN, mx});
            win.delete();
          end
        end else if (!enable && (cyc - last_rd > 2)) begin
          win.delete();
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] l, input logic [31:0] r);
    bit got;
    got = 0;
    aif.left_channel_audio_in  = l;
    aif.right_channel_audio_in = r;
    aif.audio_in_available     = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge CLOCK_50);
      if (aif.read_audio_in) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no read strobe expected strobe within 12 cycles");
    end
    @(posedge CLOCK_50);
    #1 aif.audio_in_available = 1'b0;
  endtask

  task automatic send_mag(input logic [15:0] m);
    send({m, 16'h0000}, {m, 16'h0000});
  endtask

  task automatic window4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    send_mag(a); send_mag(b); send_mag(c); send_mag(d);
  endtask

  // From the cycle after the last strobe to the blow_pulse cycle.
  task automatic settle();
    repeat (3) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    aif.audio_in_available     = 1'b0;
    aif.left_channel_audio_in  = '0;
    aif.right_channel_audio_in = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("lit_rst_level", level, 0);
    check("lit_rst_blow",  blow_active, 0);
    resetn = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;

    // 1: constant 0x1000 on both channels
    for (int i = 0; i < WIN; i++) send(32'h1000_0000, 32'h1000_0000);
    settle();
    check("lit_t1_level", level, 4096);
    check("lit_t1_peak",  peak, 4096);

    // 2: saturation of -32768 averaged with zero
    for (int i = 0; i < WIN; i++) send(32'h8000_0000, 32'h0000_0000);
    settle();
    check("lit_t2_level", level, 16383);

    // 3: ramp window, then an all-zero window
    window4(100, 200, 300, 400);
    settle();
    check("lit_t3_level", level, 250);
    check("lit_t3_peak",  peak, 400);
    window4(0, 0, 0, 0);
    settle();
    check("lit_t3z_level", level, 0);
    check("lit_t3z_peak",  peak, 0);

    // 4: hysteresis detector
    th_on = 16'd1000;
    th_off = 16'd500;
    window4(1200, 1200, 1200, 1200); settle();
    check("lit_t4a_blow", blow_active, 1); check("lit_t4a_pulse", blow_pulse, 1);
    window4(700, 700, 700, 700);     settle();
    check("lit_t4b_blow", blow_active, 1); check("lit_t4b_pulse", blow_pulse, 0);
    window4(400, 400, 400, 400);     settle();
    check("lit_t4c_blow", blow_active, 0); check("lit_t4c_pulse", blow_pulse, 0);
    window4(1200, 1200, 1200, 1200); settle();
    check("lit_t4d_blow", blow_active, 1); check("lit_t4d_pulse", blow_pulse, 1);

    // 5: enable dropped mid-window discards the partial window
    send_mag(2000);
    send_mag(2000);
    enable = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1 enable = 1'b1;
    window4(800, 800, 800, 800);
    settle();
    check("lit_t5_level", level, 800);
    check("lit_t5_peak",  peak, 800);

    // 6: asynchronous reset while in MAG
    aif.left_channel_audio_in  = 32'h1388_0000;
    aif.right_channel_audio_in = 32'h1388_0000;
    aif.audio_in_available     = 1'b1;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
        @(negedge CLOCK_50);
        if (aif.read_audio_in) got = 1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL t6_strobe: got no read strobe expected strobe within 12 cycles");
      end
    end
    @(posedge CLOCK_50);
    #2 resetn = 1'b0;
    #1;
    check("lit_t6_level", level, 0);
    check("lit_t6_blow",  blow_active, 0);
    check("lit_t6_read",  aif.read_audio_in, 0);
    aif.audio_in_available = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1;
    window4(300, 300, 300, 300);
    settle();
    check("lit_t6_relevel", level, 300);
    check("lit_t6_repeak",  peak, 300);

    repeat (4) @(posedge CLOCK_50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
